keysched: RTL and testbench

KEYSCHED -- requirements
Module: keysched

---
 rtl/keysched.sv | 134 +++++++++++++
 tb/tb_keysched.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keysched.sv
// rtl/keysched.sv - 16-round key schedule generator with forward and reverse ordering
//
// Produces the sixteen 56-bit round values {C,D} from a permuted-choice key,
// one per consumer acknowledgement. C and D rotate independently as 28-bit
// circular words. Encrypt walks left rotations from K1 to K16. Decrypt starts
// from the unrotated key, which equals K16, and walks right rotations back to K1.
//
// Ports:
//   keysched_clk     in   clock, rising edge
//   keysched_rst     in   asynchronous active-high reset
//   keysched_din     in   56-bit key, C0 = din[55:28], D0 = din[27:0]
//   keysched_start   in   begin a schedule; honoured only when idle
//   keysched_decrypt in   mode captured with start: 1 = decrypt, 0 = encrypt
//   keysched_next    in   acknowledge the current round key and advance
//   keysched_key     out  current round value {C,D}
//   keysched_round   out  current round index 0..15
//   keysched_valid   out  key/round hold a valid round key
//   keysched_busy    out  schedule in progress
//   keysched_done    out  one-cycle pulse after the last key is acknowledged

module keysched (
    input  logic        keysched_clk,
    input  logic        keysched_rst,
    input  logic [55:0] keysched_din,
    input  logic        keysched_start,
    input  logic        keysched_decrypt,
    input  logic        keysched_next,
    output logic [55:0] keysched_key,
    output logic [3:0]  keysched_round,
    output logic        keysched_valid,
    output logic        keysched_busy,
    output logic        keysched_done
);

    typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [55:0] key_q, key_d;
    logic [3:0]  round_q, round_d;
    logic        mode_q, mode_d;
    logic        done_q, done_d;

    // The shift table s(r) for r = 1..16 is 1 at r = 1, 2, 9 and 16, and 2 elsewhere.
    // This returns 1 when the rotation for round r is two bits.
    function automatic logic shift_two(input logic [4:0] r);
        shift_two = !((r == 5'd1) || (r == 5'd2) || (r == 5'd9) || (r == 5'd16));
    endfunction

    function automatic logic [27:0] rotl28(input logic [27:0] x, input logic two);
        rotl28 = two ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
    endfunction

    function automatic logic [27:0] rotr28(input logic [27:0] x, input logic two);
        rotr28 = two ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
    endfunction

    // Stepping from index n uses s(n+2) for encrypt and s(16-n) for decrypt.
    logic [4:0] enc_r, dec_r;
    logic       step_two;
    assign enc_r    = {1'b0, round_q} + 5'd2;
    assign dec_r    = 5'd16 - {1'b0, round_q};
    assign step_two = mode_q ? shift_two(dec_r) : shift_two(enc_r);

    // State register.
    always_ff @(posedge keysched_clk or posedge keysched_rst) begin
        if (keysched_rst) begin
            state_q <= S_IDLE;
            key_q   <= 56'd0;
            round_q <= 4'd0;
            mode_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic. Key and round keep their last values after the final round.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (keysched_start) begin
                    state_d = S_ACTIVE;
                    mode_d  = keysched_decrypt;
                    round_d = 4'd0;
                    // Encrypt index 0 is K1 = rotl by s(1) = 1. Decrypt index 0 is the
                    // raw key, because the total rotation of 28 bits returns to the start.
                    if (keysched_decrypt) begin
                        key_d = keysched_din;
                    end else begin
                        key_d = {rotl28(keysched_din[55:28], 1'b0),
                                 rotl28(keysched_din[27:0],  1'b0)};
                    end
                end
            end
            S_ACTIVE: begin
                if (keysched_next) begin
                    if (round_q == 4'd15) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        round_d = round_q + 4'd1;
                        if (mode_q) begin
                            key_d = {rotr28(key_q[55:28], step_two),
                                     rotr28(key_q[27:0],  step_two)};
                        end else begin
                            key_d = {rotl28(key_q[55:28], step_two),
                                     rotl28(key_q[27:0],  step_two)};
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic. Every output is taken directly from a register.
    always_comb begin
        keysched_key   = key_q;
        keysched_round = round_q;
        keysched_valid = (state_q == S_ACTIVE);
        keysched_busy  = (state_q == S_ACTIVE);
        keysched_done  = done_q;
    end

endmodule

// File: tb/tb_keysched.sv
// tb/tb_keysched.sv - scoreboard bench for keysched

module tb_keysched;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [55:0] din = 56'd0;
    logic        start = 1'b0;
    logic        decrypt = 1'b0;
    logic        next = 1'b0;
    logic [55:0] key;
    logic [3:0]  round;
    logic        valid, busy, done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit          is_done;
        logic [55:0] key;
        logic [3:0]  round;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    keysched dut (
        .keysched_clk     (clk),
        .keysched_rst     (rst),
        .keysched_din     (din),
        .keysched_start   (start),
        .keysched_decrypt (decrypt),
        .keysched_next    (next),
        .keysched_key     (key),
        .keysched_round   (round),
        .keysched_valid   (valid),
        .keysched_busy    (busy),
        .keysched_done    (done)
    );

    always #5 clk = ~clk;

    // Cumulative left rotation of encrypt index n (K(n+1)).
    function automatic int cum_shift(input int n);
        case (n)
            0: cum_shift = 1;   1: cum_shift = 2;   2: cum_shift = 4;   3: cum_shift = 6;
            4: cum_shift = 8;   5: cum_shift = 10;  6: cum_shift = 12;  7: cum_shift = 14;
            8: cum_shift = 15;  9: cum_shift = 17;  10: cum_shift = 19; 11: cum_shift = 21;
            12: cum_shift = 23; 13: cum_shift = 25; 14: cum_shift = 27; default: cum_shift = 28;
        endcase
    endfunction

    function automatic logic [55:0] enc_key(input logic [55:0] d, input int n);
        logic [27:0] c, dd;
        c  = d[55:28];
        dd = d[27:0];
        for (int k = 0; k < cum_shift(n); k++) begin
            c  = {c[26:0], c[27]};
            dd = {dd[26:0], dd[27]};
        end
        return {c, dd};
    endfunction

    function automatic logic [55:0] exp_key(input logic [55:0] d, input logic dec, input int n,
                                            input bit hand);
        logic [55:0] k;
        k = dec ? enc_key(d, 15 - n) : enc_key(d, n);
        if (hand) begin
            if (!dec && n == 0)  k = {28'h0000002, 28'h0000001};
            if (!dec && n == 2)  k = {28'h0000010, 28'h0000008};
            if (dec && n == 0)   k = {28'h0000001, 28'h8000000};
            if (dec && n == 1)   k = {28'h8000000, 28'h4000000};
            if (dec && n == 15)  k = {28'h0000002, 28'h0000001};
        end
        return k;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [55:0] act, input logic [55:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic push_key(input logic [55:0] k, input int n);
        exp_t e;
        e.is_done = 1'b0;
        e.key     = k;
        e.round   = 4'(n);
        exp_q.push_back(e);
    endtask

    task automatic push_done(input logic [55:0] k);
        exp_t e;
        e.is_done = 1'b1;
        e.key     = k;
        e.round   = 4'd15;
        exp_q.push_back(e);
    endtask

    // Runs one schedule. next is driven together with start to show it is ignored
    // in IDLE. hold_at stalls for five cycles there and pulses start mid-schedule.
    // abort_at leaves the schedule parked at that round with next low.
    task automatic run(input logic [55:0] d, input logic dec, input int hold_at,
                       input int abort_at, input bit hand);
        logic [55:0] k;
        din     = d;
        decrypt = dec;
        start   = 1'b1;
        next    = 1'b1;
        tick();
        start   = 1'b0;
        for (int n = 0; n < 16; n++) begin
            k = exp_key(d, dec, n, hand);
            if (n == abort_at) begin
                next = 1'b0;
                return;
            end
            if (n == hold_at) begin
                next    = 1'b0;
                start   = 1'b1;
                din     = ~d;
                decrypt = ~dec;
                for (int h = 0; h < 5; h++) begin
                    tick();
                    start = 1'b0;
                    check("hold_key", key, k);
                    check("hold_round", 56'(round), 56'(n));
                    check("hold_valid", 56'(valid), 56'd1);
                end
            end
            push_key(k, n);
            if (n == 15) push_done(k);
            next = 1'b1;
            tick();
        end
        next = 1'b0;
    endtask

    // Scoreboard monitor: consumes one entry per acknowledged key and per done pulse.
    always @(negedge clk) begin
        if (!rst) begin
            if (valid && next) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_key: unexpected key %h round %0d", key, round);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.is_done || key !== mon_e.key || round !== mon_e.round) begin
                        errors++;
                        $display("FAIL sb_key: got key %h round %0d expected key %h round %0d done_expected %0d",
                                 key, round, mon_e.key, mon_e.round, mon_e.is_done);
                    end
                end
            end
            if (done) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_done: unexpected done pulse");
                end else begin
                    mon_e = exp_q.pop_front();
                    if (!mon_e.is_done || key !== mon_e.key || round !== mon_e.round || valid || busy) begin
                        errors++;
                        $display("FAIL sb_done: got key %h round %0d valid %0d busy %0d expected key %h round %0d done_expected %0d",
                                 key, round, valid, busy, mon_e.key, mon_e.round, mon_e.is_done);
                    end
                end
            end
        end
    end

    logic [55:0] d1, r1, r2, r3, r4;
    logic [63:0] rnd;

    initial begin
        d1 = {28'h0000001, 28'h8000000};
        rnd = {$urandom, $urandom}; r1 = rnd[55:0];
        rnd = {$urandom, $urandom}; r2 = rnd[55:0];
        rnd = {$urandom, $urandom}; r3 = rnd[55:0];
        rnd = {$urandom, $urandom}; r4 = rnd[55:0];

        tick();
        tick();
        check("reset_key", key, 56'd0);
        check("reset_round", 56'(round), 56'd0);
        check("reset_valid", 56'(valid), 56'd0);
        check("reset_busy", 56'(busy), 56'd0);
        check("reset_done", 56'(done), 56'd0);
        rst = 1'b0;
        tick();

        // Directed encrypt vector, then next in IDLE must not disturb anything.
        run(d1, 1'b0, -1, -1, 1'b1);
        tick();
        tick();
        next = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("idle_next_valid", 56'(valid), 56'd0);
            check("idle_next_round", 56'(round), 56'd15);
            check("idle_next_key", key, enc_key(d1, 15));
        end
        next = 1'b0;
        tick();

        // Directed decrypt vector.
        run(d1, 1'b1, -1, -1, 1'b1);
        tick();

        // Mixed-mode sweep with backpressure; each run after the first starts in the done cycle.
        run(r1, 1'b0, 3, -1, 1'b0);
        run(r1, 1'b1, -1, -1, 1'b0);
        run(r2, 1'b1, 3, -1, 1'b0);
        run(r2, 1'b0, -1, -1, 1'b0);
        tick();
        tick();

        // Reset in the middle of a schedule.
        run(r3, 1'b0, -1, 7, 1'b0);
        check("pre_reset_round", 56'(round), 56'd7);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_key", key, 56'd0);
        check("async_rst_round", 56'(round), 56'd0);
        check("async_rst_valid", 56'(valid), 56'd0);
        check("async_rst_busy", 56'(busy), 56'd0);
        check("async_rst_done", 56'(done), 56'd0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        check("post_rst_done", 56'(done), 56'd0);
        run(r4, 1'b0, -1, -1, 1'b0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("sb_drained", 56'(exp_q.size()), 56'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
